systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Transmit-side front end for the systolic array wrapper. Accepts A-row/B-column operand vectors from upstream over a valid/ready stream and buffers them in a small FIFO. Replays them as the wrapper's free-running `a`/`b`/`en`/`last` input, one vector pair per cycle. After each tile it enforces the drain gap the wrapper needs, so a new tile never starts while results are still draining.

## Interface
- `SIZE`, default `SYS_ARRAY_SIZE`: lanes per operand vector.
- `FIFO_DEPTH`, default 4: operand buffer entries; power of two, ≥2.
- `MAX_TILE_LEN`, default 64: maximum beats per tile before a forced tile end.
- `DRAIN_CYCLES`, default `2*SIZE+2`: idle cycles required after a `last_o` beat.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `a_i`, in, `data_t[SIZE]`: A operand vector.
- `b_i`, in, `data_t[SIZE]`: B operand vector.
- `last_i`, in, 1: beat is the final beat of its tile.
- `valid_i`, in, 1: upstream beat valid.
- `ready_o`, out, 1: FIFO can accept a beat.
- `a_o`, out, `data_t[SIZE]`: to wrapper `a`.
- `b_o`, out, `data_t[SIZE]`: to wrapper `b`.
- `en_o`, out, 1: to wrapper `en_i`.
- `last_o`, out, 1: to wrapper `last_i`.
- `busy_o`, out, 1: state is not IDLE, or the FIFO is non-empty.
- `err_o`, out, 1: sticky; set when a tile was force-terminated.

## Operation
- **Push.** A beat is pushed on `valid_i && ready_o`. `ready_o = !full`, with no combinational dependence on pop. A push while full cannot occur.
- **States.**
  - IDLE → STREAM on the first pop.
  - STREAM → DRAIN when the popped beat ends the tile.
  - DRAIN → STREAM if the FIFO is non-empty when the counter expires, else → IDLE.
- **Pop.** Pops happen in IDLE or STREAM whenever the FIFO is non-empty, at one pop per cycle.
- **Popped beat.** On the next edge it drives `a_o`/`b_o`, `en_o=1`, and `last_o = entry.last || forced`.
- **FIFO empty mid-tile.** The state stays STREAM. `en_o=0` for that cycle (a bubble) and `a_o`/`b_o` hold their values. Bubbles do not count toward the drain.
- **Beat counter.** Counts popped beats of the current tile.
  - When the MAX_TILE_LEN-th beat has `last=0`, it is emitted with `last_o=1` (forced) and `err_o` is set.
  - The following beats start a new tile.
  - `err_o` clears only on reset.
- **DRAIN.**
  - Counter loads `DRAIN_CYCLES` when `last_o` is emitted and decrements each cycle.
  - No pops occur; `en_o=0` and `last_o=0`.
  - Pushes continue.
- **Single-beat tile.** `last_i` on the first beat is legal: one beat, then drain.
- **Reset.** At any time, including mid-tile or mid-drain, reset empties the FIFO and clears the counters. State returns to IDLE and every output goes to 0, including `ready_o`, which rises on the first cycle after reset deassertion.

## Timing
- Push to earliest `en_o`: 2 cycles. The beat is written at edge T, popped at T+1, and shown on the outputs after T+1.
- `last_o` high in cycle T means `en_o=0` for cycles T+1 … T+DRAIN_CYCLES. The earliest next `en_o=1` is cycle T+DRAIN_CYCLES+1.
- Throughput: 1 beat/cycle within a tile while the FIFO is non-empty.
- All outputs are registered.

## Configuration
- **`FEEDER_STATS_EN` defined:**
  - Adds output `tiles_o` (32b), which increments on each `last_o` beat.
  - Adds output `bubbles_o` (32b), which increments on each in-tile `en_o=0` cycle in STREAM.
  - Both wrap at 2^32 and reset to 0.
- **`FEEDER_STATS_EN` undefined:** these ports and counters do not exist, and all other behaviour is identical.

## Structure
- **common_pkg additions:**
  - `feeder_state_e` (IDLE, STREAM, DRAIN).
  - `feeder_entry_t` (`a`, `b`, `last`).
  - `FEEDER_DRAIN_CYCLES = 2*SYS_ARRAY_SIZE+2`.
  - Existing `data_t` is reused.
- **Sub-module `feeder_fifo`:** synchronous FIFO of `feeder_entry_t` with push/pop/full/empty, pointers one bit wider than the address. It resets asynchronously on `rst_ni`.

## Test plan
All scenarios use SIZE=4, DRAIN_CYCLES=10, FIFO_DEPTH=4, MAX_TILE_LEN=8.
- **Back-to-back tiles.** Push 3 beats (last on the 3rd), then 3 more back-to-back → `en_o` high for 3 consecutive cycles. `last_o` is high on the 3rd, followed by exactly 10 `en_o=0` cycles, then the second tile.
- **Backpressure.** Hold `valid_i=1` with 12 beats while the feeder is stalled in drain → `ready_o` drops after 4 buffered beats. No beat is lost or duplicated and output order matches input.
- **Mid-tile bubble.** Upstream gaps 2 cycles mid-tile → exactly 2 `en_o=0` cycles inside the tile. The state stays STREAM and the drain starts only after `last_o`.
- **Forced tile end.** 9 beats with no `last_i` → `last_o=1` on beat 8, then `err_o=1` and a 10-cycle drain. Beat 9 is emitted as a new tile.
- **Reset mid-drain.** Assert `rst_ni=0` 4 cycles into a drain → all outputs are 0 and the FIFO is empty. After release, a new beat appears on `en_o` 2 cycles after push with no residual drain.
- **Stats (`FEEDER_STATS_EN` defined).** Run the scenario 1 and mid-tile-bubble streams → `tiles_o` and `bubbles_o` match the counts of `last_o` beats and in-tile bubbles.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder_pkg
// Brief    : Shared types and constants for the systolic array feeder.
// Revision : 1.0 - initial release
// ============================================================================
package systolic_feeder_pkg;

    localparam int SYS_ARRAY_SIZE      = 4;
    localparam int DATA_W              = 8;
    localparam int FEEDER_DRAIN_CYCLES = 2 * SYS_ARRAY_SIZE + 2;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    typedef struct packed {
        data_t [SYS_ARRAY_SIZE-1:0] a;
        data_t [SYS_ARRAY_SIZE-1:0] b;
        logic                       last;
    } feeder_entry_t;

endpackage
`default_nettype wire

// File: rtl/feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module   : feeder_fifo
// Brief    : Synchronous operand FIFO with wrap-bit pointers and fill level.
// Revision : 1.0 - initial release
// ============================================================================
module feeder_fifo
    import systolic_feeder_pkg::*;
#(
    parameter type ENTRY_T = feeder_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_push,
    input  ENTRY_T                 i_wdata,
    input  logic                   i_pop,
    output ENTRY_T                 o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int c_AW = $clog2(DEPTH);

    ENTRY_T          r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot, opposite lap: the writer has wrapped once past the reader.
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feeder
// Brief    : Buffers operand beats and replays them to the systolic wrapper,
//            inserting the result drain gap after every tile.
//            Optional: FEEDER_STATS_EN adds tiles_o / bubbles_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int SIZE         = SYS_ARRAY_SIZE,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_TILE_LEN = 64,
    parameter int DRAIN_CYCLES = 2 * SIZE + 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [SIZE*DATA_W-1:0] a_i,
    input  logic [SIZE*DATA_W-1:0] b_i,
    input  logic                   last_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [SIZE*DATA_W-1:0] a_o,
    output logic [SIZE*DATA_W-1:0] b_o,
    output logic                   en_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   err_o
`ifdef FEEDER_STATS_EN
    ,
    output logic [31:0]            tiles_o,
    output logic [31:0]            bubbles_o
`endif
);

    localparam int c_VEC_W  = SIZE * DATA_W;
    localparam int c_LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_BEAT_W = $clog2(MAX_TILE_LEN + 1);
    localparam int c_DRN_W  = $clog2(DRAIN_CYCLES + 1);

    typedef struct packed {
        logic [c_VEC_W-1:0] a;
        logic [c_VEC_W-1:0] b;
        logic               last;
    } entry_t;

    feeder_state_e        r_state;
    feeder_state_e        w_state_nxt;
    entry_t               w_wr_entry;
    entry_t               w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_forced;
    logic                 w_last_out;
    logic [c_LVL_W-1:0]   w_level;
    logic [c_LVL_W-1:0]   w_level_nxt;

    logic [c_VEC_W-1:0]   r_a;
    logic [c_VEC_W-1:0]   r_b;
    logic                 r_en;
    logic                 r_last;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_err;
    logic [c_BEAT_W-1:0]  r_beat_cnt;
    logic [c_DRN_W-1:0]   r_drain_cnt;

    assign w_wr_entry  = '{a: a_i, b: b_i, last: last_i};
    assign w_push      = valid_i && r_ready && !w_full;
    assign w_level_nxt = w_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);

    feeder_fifo #(
        .ENTRY_T (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_pop       = !w_empty && (r_state != DRAIN);
        w_forced    = (r_beat_cnt == c_BEAT_W'(MAX_TILE_LEN - 1)) && !w_head.last;
        w_last_out  = w_head.last || w_forced;
        w_state_nxt = r_state;
        case (r_state)
            IDLE, STREAM: begin
                if (w_pop) w_state_nxt = w_last_out ? DRAIN : STREAM;
            end
            DRAIN: begin
                // Counter was loaded with the last_o beat, so expiry lands
                // exactly DRAIN_CYCLES idle outputs later.
                if (r_drain_cnt == c_DRN_W'(1)) w_state_nxt = w_empty ? IDLE : STREAM;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a         <= '0;
            r_b         <= '0;
            r_en        <= 1'b0;
            r_last      <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_ready <= (w_level_nxt != c_LVL_W'(FIFO_DEPTH));
            r_busy  <= (w_state_nxt != IDLE) || (w_level_nxt != '0);
            r_en    <= w_pop;
            r_last  <= w_pop && w_last_out;
            if (w_pop) begin
                r_a        <= w_head.a;
                r_b        <= w_head.b;
                r_beat_cnt <= w_last_out ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_pop && w_forced) r_err <= 1'b1;
            if (w_pop && w_last_out)
                r_drain_cnt <= c_DRN_W'(DRAIN_CYCLES);
            else if (r_drain_cnt != '0)
                r_drain_cnt <= r_drain_cnt - 1'b1;
        end
    end

    assign ready_o = r_ready;
    assign a_o     = r_a;
    assign b_o     = r_b;
    assign en_o    = r_en;
    assign last_o  = r_last;
    assign busy_o  = r_busy;
    assign err_o   = r_err;

`ifdef FEEDER_STATS_EN
    logic        w_bubble;
    logic [31:0] r_tiles;
    logic [31:0] r_bubbles;

    // A STREAM cycle without a pop becomes an en_o=0 hole inside the tile.
    assign w_bubble = (r_state == STREAM) && !w_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tiles   <= '0;
            r_bubbles <= '0;
        end else begin
            if (w_pop && w_last_out) r_tiles   <= r_tiles + 32'd1;
            if (w_bubble)            r_bubbles <= r_bubbles + 32'd1;
        end
    end

    assign tiles_o   = r_tiles;
    assign bubbles_o = r_bubbles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feeder
// Brief    : Scoreboard bench for systolic_feeder (SIZE=4, DRAIN=10, DEPTH=4,
//            MAX_TILE_LEN=8). FEEDER_STATS_EN enables the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feeder;

    localparam int c_DRAIN = 10;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] a_i, b_i;
    logic        last_i, valid_i;
    logic        ready_o;
    logic [31:0] a_o, b_o;
    logic        en_o, last_o, busy_o, err_o;
`ifdef FEEDER_STATS_EN
    logic [31:0] tiles_o, bubbles_o;
`endif

    systolic_feeder #(
        .SIZE         (4),
        .FIFO_DEPTH   (4),
        .MAX_TILE_LEN (8),
        .DRAIN_CYCLES (c_DRAIN)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .a_i       (a_i),
        .b_i       (b_i),
        .last_i    (last_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_o       (a_o),
        .b_o       (b_o),
        .en_o      (en_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
`ifdef FEEDER_STATS_EN
        ,
        .tiles_o   (tiles_o),
        .bubbles_o (bubbles_o)
`endif
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   en_cycles[$];
    int   last_cycles[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   push_edge = 0;
    int   acc_cnt = 0;
    int   stalled_at = -1;
    int   last_l = 0;
    bit   have_last = 1'b0;
    exp_t e;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: scoreboard pop plus drain-gap and last/en sanity.
    initial forever begin
        @(negedge clk);
        if (!rst_ni) begin
            have_last = 1'b0;
        end else begin
            if (last_o && !en_o) check_eq("last_without_en", {63'd0, en_o}, 64'd1);
            if (en_o) begin
                en_cycles.push_back(cyc);
                if (have_last && (cyc - last_l) <= c_DRAIN)
                    check_eq("drain_gap", 64'(cyc - last_l), 64'(c_DRAIN + 1));
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("a_o", {32'd0, a_o}, {32'd0, e.a});
                    check_eq("b_o", {32'd0, b_o}, {32'd0, e.b});
                    check_eq("last_o", {63'd0, last_o}, {63'd0, e.last});
                end
            end
            if (last_o) begin
                last_cycles.push_back(cyc);
                have_last = 1'b1;
                last_l    = cyc;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic l, input logic exp_l);
        int n = 0;
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        last_i  = l;
        while (!ready_o && n < 300) begin
            if (stalled_at < 0) stalled_at = acc_cnt;
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            check_eq("send_timeout", {63'd0, ready_o}, 64'd1);
        end else begin
            sb.push_back('{a: a, b: b, last: exp_l});
            push_edge = cyc + 1;
            acc_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic gap(input int n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        valid_i = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy_o && sb.size() == 0) break;
        end
        check_eq({tag, "_idle"}, {63'd0, busy_o}, 64'd0);
        check_eq({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_a"}, {32'd0, a_o}, 64'd0);
        check_eq({tag, "_b"}, {32'd0, b_o}, 64'd0);
        check_eq({tag, "_en"}, {63'd0, en_o}, 64'd0);
        check_eq({tag, "_last"}, {63'd0, last_o}, 64'd0);
        check_eq({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
        check_eq({tag, "_err"}, {63'd0, err_o}, 64'd0);
        check_eq({tag, "_ready"}, {63'd0, ready_o}, 64'd0);
    endtask

    task automatic clear_trace();
        en_cycles.delete();
        last_cycles.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        valid_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        last_i  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst_ni = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", {63'd0, ready_o}, 64'd1);

        // Back-to-back tiles of 3
        clear_trace();
        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom, (i == 2 || i == 5), (i == 2 || i == 5));
            if (i == 0) p0 = push_edge;
        end
        wait_idle("s1");
        check_eq("s1_beats", 64'(en_cycles.size()), 64'd6);
        check_eq("s1_lasts", 64'(last_cycles.size()), 64'd2);
        if (en_cycles.size() == 6 && last_cycles.size() == 2) begin
            check_eq("s1_latency", 64'(en_cycles[0]), 64'(p0 + 1));
            check_eq("s1_gap01", 64'(en_cycles[1] - en_cycles[0]), 64'd1);
            check_eq("s1_gap12", 64'(en_cycles[2] - en_cycles[1]), 64'd1);
            check_eq("s1_drain", 64'(en_cycles[3] - en_cycles[2]), 64'(c_DRAIN + 1));
            check_eq("s1_gap34", 64'(en_cycles[4] - en_cycles[3]), 64'd1);
            check_eq("s1_gap45", 64'(en_cycles[5] - en_cycles[4]), 64'd1);
            check_eq("s1_last0", 64'(last_cycles[0]), 64'(en_cycles[2]));
            check_eq("s1_last1", 64'(last_cycles[1]), 64'(en_cycles[5]));
        end

        // Mid-tile bubble of 2 cycles
        clear_trace();
        send($urandom, $urandom, 1'b0, 1'b0);
        send($urandom, $urandom, 1'b0, 1'b0);
        gap(2);
        check_eq("s3_busy_gap", {63'd0, busy_o}, 64'd1);
        send($urandom, $urandom, 1'b0, 1'b0);
        send($urandom, $urandom, 1'b1, 1'b1);
        wait_idle("s3");
        check_eq("s3_beats", 64'(en_cycles.size()), 64'd4);
        check_eq("s3_lasts", 64'(last_cycles.size()), 64'd1);
        if (en_cycles.size() == 4 && last_cycles.size() == 1) begin
            check_eq("s3_gap01", 64'(en_cycles[1] - en_cycles[0]), 64'd1);
            check_eq("s3_bubble", 64'(en_cycles[2] - en_cycles[1]), 64'd3);
            check_eq("s3_gap23", 64'(en_cycles[3] - en_cycles[2]), 64'd1);
            check_eq("s3_last", 64'(last_cycles[0]), 64'(en_cycles[3]));
        end
`ifdef FEEDER_STATS_EN
        check_eq("stats_tiles", {32'd0, tiles_o}, 64'd3);
        check_eq("stats_bubbles", {32'd0, bubbles_o}, 64'd2);
`endif

        // Backpressure while stalled in drain
        clear_trace();
        stalled_at = -1;
        acc_cnt    = 0;
        send($urandom, $urandom, 1'b1, 1'b1);
        for (int i = 1; i <= 12; i++)
            send($urandom, $urandom, (i % 3 == 0), (i % 3 == 0));
        wait_idle("s2");
        check_eq("s2_stall_after", 64'(stalled_at), 64'd5);
        check_eq("s2_beats", 64'(en_cycles.size()), 64'd13);
        check_eq("s2_lasts", 64'(last_cycles.size()), 64'd5);

        // Forced tile end after 8 beats without last
        clear_trace();
        check_eq("s4_err_pre", {63'd0, err_o}, 64'd0);
        for (int i = 0; i < 9; i++)
            send($urandom, $urandom, 1'b0, (i == 7));
        send($urandom, $urandom, 1'b1, 1'b1);
        wait_idle("s4");
        check_eq("s4_err", {63'd0, err_o}, 64'd1);
        check_eq("s4_beats", 64'(en_cycles.size()), 64'd10);
        check_eq("s4_lasts", 64'(last_cycles.size()), 64'd2);
        if (en_cycles.size() == 10 && last_cycles.size() == 2) begin
            check_eq("s4_forced_last", 64'(last_cycles[0]), 64'(en_cycles[7]));
            check_eq("s4_drain", 64'(en_cycles[8] - en_cycles[7]), 64'(c_DRAIN + 1));
            check_eq("s4_new_tile", 64'(en_cycles[9] - en_cycles[8]), 64'd1);
        end

        // Reset four cycles into a drain with beats still buffered
        clear_trace();
        send($urandom, $urandom, 1'b1, 1'b1);
        send($urandom, $urandom, 1'b0, 1'b0);
        send($urandom, $urandom, 1'b1, 1'b1);
        valid_i = 1'b0;
        for (int k = 0; k < 50 && last_cycles.size() == 0; k++) @(negedge clk);
        check_eq("s5_saw_last", 64'(last_cycles.size()), 64'd1);
        for (int k = 0; k < 50 && last_cycles.size() > 0 && cyc < last_cycles[0] + 4; k++)
            @(negedge clk);
        #2 rst_ni = 1'b0;
        #1 check_outputs_zero("s5_rst");
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        clear_trace();
        #2 rst_ni = 1'b1;
        @(negedge clk);
        check_eq("s5_ready", {63'd0, ready_o}, 64'd1);
        send($urandom, $urandom, 1'b1, 1'b1);
        p0 = push_edge;
        wait_idle("s5");
        check_eq("s5_beats", 64'(en_cycles.size()), 64'd1);
        if (en_cycles.size() == 1)
            check_eq("s5_latency", 64'(en_cycles[0]), 64'(p0 + 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
